gene_stepper: RTL and testbench
===============================

Name: gene_stepper

Overview:
- Drives the Boolean gene network trajectory consumed by the period-2 cycle detector.
- From a start command it seeds the network state with an initial value, then applies the network update function once per clock.
- It presents each state x[t] to the detector and terminates a run on one of three conditions: a detector cycle flag, a fixed point, or a step limit.
- Optional sweep mode repeats the run for every initial value 0 .. 2^N-1 and counts how many of those runs end in a cycle.

Parameters:
- N, 8, number of genes (state width).
- MAX_STEPS, 16, maximum network updates per run before timeout (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a run; sampled in IDLE only.
- sweep  input  1  sampled with start; 1 = iterate all initial values starting at init.
- init  input  N  initial gene state for the (first) run.
- cyc_in  input  1  cycle flag from the detector.
- x  output  N  current network state x[t], to the detector.
- x_valid  output  1  x carries a live trajectory state this cycle.
- seed  output  1  one-cycle pulse when a new initial value is loaded; clears the detector.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the whole command (single run or sweep) completes.
- status  output  2  result of the last run: 0 none, 1 CYCLE, 2 FIXED, 3 TIMEOUT.
- end_state  output  N  x at termination of the last run.
- steps  output  8  updates applied in the last run.
- cyc_count  output  N+1  number of runs in the current command that ended CYCLE.

Behaviour:
- Reset (async, any state, including mid-run): state IDLE. All outputs 0: x, x_valid, seed, busy, done, status, end_state, steps, cyc_count. Internal current-init register cleared.
- Update function f(s): f(s)[i] = s[(i+1) mod N] XOR s[(i+N-1) mod N] (ring rule 90). Purely combinational.
- States: IDLE, SEED, STEP, DONE.
- IDLE:
  - start=1 → SEED.
  - Latch init into cur_init and sweep into the mode register.
  - Clear cyc_count.
  - start while busy is ignored.
- SEED (1 cycle):
  - x <= cur_init; step counter <= 0; seed=1.
  - Next state STEP.
- STEP (x_valid=1 each cycle). Evaluate on current x, first match wins:
  - (a) cyc_in=1 → run ends CYCLE, cyc_count++.
  - (b) f(x)==x → run ends FIXED.
  - (c) counter==MAX_STEPS → run ends TIMEOUT.
  - On a run end: register status, end_state=x, steps=counter; x holds.
    - Not sweeping, or cur_init == all-ones → DONE.
    - Otherwise cur_init++ and → SEED.
  - No end: x <= f(x), counter++.
- DONE (1 cycle): done=1, x_valid=0 → IDLE.
- status, end_state and steps update at the end of every run and hold until the next run end or reset. cyc_count holds until the next start.
- Sweep wrap: the last run uses cur_init = 2^N-1. cur_init never wraps back into a further run.
- Latency: start accepted at edge k; seed pulse in cycle k+1; first x_valid cycle k+2.
- cyc_count width N+1 allows 2^N without overflow.

Decomposition:
- Shared package gene_pkg: N default, status encodings (ST_NONE, ST_CYCLE, ST_FIXED, ST_TIMEOUT), FSM state enum.
- One sub-module: gene_update (combinational f(s), parameter N), reused later by other network blocks.

Test Plan:
- init=0x00, sweep=0, cyc_in=0 → FIXED on the first STEP cycle; steps=0, end_state=0x00, done one cycle later.
- init=0x01, MAX_STEPS=16 → x sequence 0x01, 0x82, 0x44, 0xAA, 0x00; FIXED, steps=4, end_state=0x00.
- init=0x01, MAX_STEPS=3 → TIMEOUT, steps=3, end_state=0xAA.
- init=0x01, cyc_in forced high while x=0x44 → CYCLE, steps=2, end_state=0x44, cyc_count=1; cyc_in outranks the fixed/timeout checks.
- N=4 sweep from init=0, bench detector model driving cyc_in → exactly 16 seed pulses and one done; cyc_count equals the model's count; second start during busy ignored.
- rst asserted mid-STEP of a sweep → all outputs 0 immediately without a clock edge; a fresh start after release behaves as a clean single run.

Source files
------------

// File: rtl/gene_pkg.sv
// Shared definitions for the Boolean gene network blocks: default network
// width, run result codes and the stepper FSM state constants.
package gene_pkg;

    localparam int GENE_N = 8;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_CYCLE   = 2'd1;
    localparam logic [1:0] ST_FIXED   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t S_IDLE = 2'd0;
    localparam fsm_state_t S_SEED = 2'd1;
    localparam fsm_state_t S_STEP = 2'd2;
    localparam fsm_state_t S_DONE = 2'd3;

endpackage

// File: rtl/gene_update.sv
// Ring rule-90 network update: each gene becomes the XOR of its two ring
// neighbours. Purely combinational.
module gene_update
    import gene_pkg::*;
#(
    parameter int N = GENE_N
) (
    input  logic [N-1:0] s,
    output logic [N-1:0] f
);

    for (genvar i = 0; i < N; i++) begin : g_gene
        assign f[i] = s[(i + 1) % N] ^ s[(i + N - 1) % N];
    end

endmodule

// File: rtl/gene_stepper.sv
// Steps the gene network from a seed value until a detector cycle, a fixed
// point or a step limit; optionally sweeps every initial value.
module gene_stepper
    import gene_pkg::*;
#(
    parameter int N         = GENE_N,
    parameter int MAX_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sweep,
    input  logic [N-1:0]     init,
    input  logic             cyc_in,
    output logic [N-1:0]     x,
    output logic             x_valid,
    output logic             seed,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [N-1:0]     end_state,
    output logic [7:0]       steps,
    output logic [N:0]       cyc_count,
    output fsm_state_t       dbg_state
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

    fsm_state_t   state_q, state_d;
    logic         mode_q, mode_d;
    logic [N-1:0] cur_init_q, cur_init_d;
    logic [N-1:0] x_q, x_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [1:0]   status_q, status_d;
    logic [N-1:0] end_q, end_d;
    logic [7:0]   steps_q, steps_d;
    logic [N:0]   cc_q, cc_d;
    logic [N-1:0] fx;
    logic         run_end;
    logic [1:0]   run_status;

    gene_update #(.N(N)) u_update (
        .s (x_q),
        .f (fx)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cur_init_d = cur_init_q;
        x_d        = x_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        end_d      = end_q;
        steps_d    = steps_q;
        cc_d       = cc_q;
        run_end    = 1'b0;
        run_status = ST_NONE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SEED;
                    cur_init_d = init;
                    mode_d     = sweep;
                    cc_d       = '0;
                end
            end
            S_SEED: begin
                x_d     = cur_init_q;
                cnt_d   = '0;
                state_d = S_STEP;
            end
            S_STEP: begin
                // Priority: detector cycle, then fixed point, then step limit.
                run_end = 1'b1;
                if (cyc_in) begin
                    run_status = ST_CYCLE;
                    cc_d       = cc_q + {{N{1'b0}}, 1'b1};
                end else if (fx == x_q) begin
                    run_status = ST_FIXED;
                end else if (cnt_q == MAX_CNT) begin
                    run_status = ST_TIMEOUT;
                end else begin
                    run_end = 1'b0;
                end
                if (run_end) begin
                    status_d = run_status;
                    end_d    = x_q;
                    steps_d  = cnt_q;
                    if (!mode_q || (&cur_init_q)) begin
                        state_d = S_DONE;
                    end else begin
                        cur_init_d = cur_init_q + {{(N-1){1'b0}}, 1'b1};
                        state_d    = S_SEED;
                    end
                end else begin
                    x_d   = fx;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            cur_init_q <= '0;
            x_q        <= '0;
            cnt_q      <= '0;
            status_q   <= ST_NONE;
            end_q      <= '0;
            steps_q    <= '0;
            cc_q       <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cur_init_q <= cur_init_d;
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            end_q      <= end_d;
            steps_q    <= steps_d;
            cc_q       <= cc_d;
        end
    end

    assign x         = x_q;
    assign x_valid   = (state_q == S_STEP);
    assign seed      = (state_q == S_SEED);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign status    = status_q;
    assign end_state = end_q;
    assign steps     = steps_q;
    assign cyc_count = cc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gene_stepper.sv
// Bench for gene_stepper: three configurations driven with random and
// directed commands, checked every cycle against a run-level network model.
module tb_gene_stepper;
    import gene_pkg::*;

    localparam int NI = 3;
    int cfg_n   [NI] = '{8, 8, 4};
    int cfg_max [NI] = '{16, 3, 3};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start_v [NI];
    logic sweep_v [NI];
    logic cyc_v   [NI];
    logic [7:0] init_a, init_b;
    logic [3:0] init_c;

    logic [7:0] x_a, x_b, end_a, end_b;
    logic [3:0] x_c, end_c;
    logic [8:0] cc_a, cc_b;
    logic [4:0] cc_c;

    logic [15:0] x_w [NI];
    logic [15:0] end_w [NI];
    logic [15:0] cc_w [NI];
    logic [7:0]  steps_w [NI];
    logic [1:0]  status_w [NI];
    logic [1:0]  dbg_w [NI];
    logic        xv_w [NI], seed_w [NI], busy_w [NI], done_w [NI];

    gene_stepper #(.N(8), .MAX_STEPS(16)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .sweep(sweep_v[0]), .init(init_a),
        .cyc_in(cyc_v[0]), .x(x_a), .x_valid(xv_w[0]), .seed(seed_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .status(status_w[0]), .end_state(end_a), .steps(steps_w[0]),
        .cyc_count(cc_a), .dbg_state(dbg_w[0])
    );
    gene_stepper #(.N(8), .MAX_STEPS(3)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .sweep(sweep_v[1]), .init(init_b),
        .cyc_in(cyc_v[1]), .x(x_b), .x_valid(xv_w[1]), .seed(seed_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .status(status_w[1]), .end_state(end_b), .steps(steps_w[1]),
        .cyc_count(cc_b), .dbg_state(dbg_w[1])
    );
    gene_stepper #(.N(4), .MAX_STEPS(3)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .sweep(sweep_v[2]), .init(init_c),
        .cyc_in(cyc_v[2]), .x(x_c), .x_valid(xv_w[2]), .seed(seed_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .status(status_w[2]), .end_state(end_c), .steps(steps_w[2]),
        .cyc_count(cc_c), .dbg_state(dbg_w[2])
    );

    assign x_w[0] = 16'(x_a);     assign x_w[1] = 16'(x_b);     assign x_w[2] = 16'(x_c);
    assign end_w[0] = 16'(end_a); assign end_w[1] = 16'(end_b); assign end_w[2] = 16'(end_c);
    assign cc_w[0] = 16'(cc_a);   assign cc_w[1] = 16'(cc_b);   assign cc_w[2] = 16'(cc_c);

    // One expected output vector per busy cycle, plus the cyc_in to drive then.
    typedef struct {
        logic [61:0] v;
        logic        drive;
    } ent_t;

    ent_t exp_q [NI][$];
    logic [15:0] trace_q [$];

    logic [15:0] m_x [NI], m_end [NI], m_cc [NI];
    logic [7:0]  m_steps [NI];
    logic [1:0]  m_status [NI];

    int checks = 0;
    int errors = 0;
    int seed_cnt [NI];
    int done_cnt [NI];
    bit chk_on = 1'b0;

    function automatic logic [61:0] pk(logic [15:0] xx, logic xv, logic sd, logic bz,
                                       logic dn, logic [1:0] st, logic [15:0] es,
                                       logic [7:0] sp, logic [15:0] cc);
        return {xx, xv, sd, bz, dn, st, es, sp, cc};
    endfunction

    function automatic logic [61:0] act_vec(int i);
        return pk(x_w[i], xv_w[i], seed_w[i], busy_w[i], done_w[i], status_w[i],
                  end_w[i], steps_w[i], cc_w[i]);
    endfunction

    function automatic logic [15:0] net_f(logic [15:0] s, int n);
        logic [15:0] r = '0;
        for (int g = 0; g < n; g++) r[g] = s[(g + 1) % n] ^ s[(g + n - 1) % n];
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NI; i++) begin
            m_x[i] = '0; m_end[i] = '0; m_cc[i] = '0; m_steps[i] = '0; m_status[i] = ST_NONE;
            exp_q[i].delete();
        end
    endfunction

    // kfix >= 0: detector fires at that step; -1 never; -2 random per run.
    function automatic void build_cmd(int i, logic [15:0] init0, bit sw, int kfix);
        int n = cfg_n[i];
        int mx = cfg_max[i];
        logic [15:0] all = 16'((1 << n) - 1);
        logic [15:0] cur = init0;
        logic [15:0] s;
        logic [1:0] st;
        int t, k;
        bit more = 1'b1;
        bit ended;
        ent_t e;
        m_cc[i] = '0;
        while (more) begin
            e.v = pk(m_x[i], 0, 1, 1, 0, m_status[i], m_end[i], m_steps[i], m_cc[i]);
            e.drive = 1'b0;
            exp_q[i].push_back(e);
            s = cur; t = 0; ended = 1'b0; st = ST_NONE;
            if (kfix != -2) k = kfix;
            else k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, mx)) : -1;
            while (!ended) begin
                e.v = pk(s, 1, 0, 1, 0, m_status[i], m_end[i], m_steps[i], m_cc[i]);
                e.drive = (t == k);
                exp_q[i].push_back(e);
                if (t == k) begin
                    st = ST_CYCLE; m_cc[i] = m_cc[i] + 16'd1; ended = 1'b1;
                end else if (net_f(s, n) == s) begin
                    st = ST_FIXED; ended = 1'b1;
                end else if (t == mx) begin
                    st = ST_TIMEOUT; ended = 1'b1;
                end else begin
                    s = net_f(s, n); t++;
                end
            end
            m_status[i] = st; m_end[i] = s; m_steps[i] = 8'(t); m_x[i] = s;
            if (!sw || cur == all) more = 1'b0;
            else cur = cur + 16'd1;
        end
        e.v = pk(m_x[i], 0, 0, 1, 1, m_status[i], m_end[i], m_steps[i], m_cc[i]);
        e.drive = 1'b0;
        exp_q[i].push_back(e);
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_zero(int i, string name);
        checks++;
        if (act_vec(i) !== 62'd0) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want 0", name, i, act_vec(i));
        end
    endtask

    task automatic set_init(int i, logic [15:0] iv);
        case (i)
            0: init_a = iv[7:0];
            1: init_b = iv[7:0];
            default: init_c = iv[3:0];
        endcase
    endtask

    task automatic run_cmd(int i, logic [15:0] iv, bit sw, int kfix);
        @(negedge clk); #1;
        set_init(i, iv);
        sweep_v[i] = sw;
        start_v[i] = 1'b1;
        build_cmd(i, iv, sw, kfix);
        @(negedge clk); #1;
        start_v[i] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int c = 0;
        while (exp_q[i].size() > 0 && c < 6000) begin
            @(negedge clk);
            c++;
        end
        if (exp_q[i].size() > 0) begin
            checks++; errors++;
            $display("FAIL wait_idle[%0d]: %0d cycles pending after budget", i, exp_q[i].size());
            exp_q[i].delete();
        end
        @(negedge clk);
    endtask

    // Compare process: every cycle, every instance, full output vector.
    initial begin
        ent_t e;
        logic [61:0] exp_v;
        forever begin
            @(negedge clk);
            if (!rst && chk_on) begin
                for (int i = 0; i < NI; i++) begin
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        exp_v = e.v;
                        cyc_v[i] = e.drive;
                    end else begin
                        exp_v = pk(m_x[i], 0, 0, 0, 0, m_status[i], m_end[i], m_steps[i], m_cc[i]);
                        cyc_v[i] = 1'b0;
                    end
                    checks++;
                    if (act_vec(i) !== exp_v) begin
                        errors++;
                        $display("FAIL cycle[%0d] t=%0t: got %h want %h", i, $time, act_vec(i), exp_v);
                    end
                    if (seed_w[i]) seed_cnt[i]++;
                    if (done_w[i]) done_cnt[i]++;
                end
                if (xv_w[0]) trace_q.push_back(x_w[0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tr_exp [5];
        tr_exp = '{16'h01, 16'h82, 16'h44, 16'hAA, 16'h00};
        rst = 1'b1;
        init_a = '0; init_b = '0; init_c = '0;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0; sweep_v[i] = 1'b0; cyc_v[i] = 1'b0;
            seed_cnt[i] = 0; done_cnt[i] = 0;
        end
        model_clear();
        #2;
        for (int i = 0; i < NI; i++) check_zero(i, "reset");
        @(negedge clk); #1;
        rst = 1'b0;
        chk_on = 1'b1;

        // init 0: immediate fixed point
        run_cmd(0, 16'h00, 1'b0, -1);
        wait_idle(0);
        chk("zero_status", 16'(status_w[0]), 16'(ST_FIXED));
        chk("zero_steps", 16'(steps_w[0]), 16'd0);
        chk("zero_end", end_w[0], 16'h00);

        // init 1: known trajectory to 0
        trace_q.delete();
        run_cmd(0, 16'h01, 1'b0, -1);
        wait_idle(0);
        chk("trace_len", 16'(trace_q.size()), 16'd5);
        for (int j = 0; j < 5; j++)
            if (j < trace_q.size()) chk("trace_x", trace_q[j], tr_exp[j]);
        chk("one_status", 16'(status_w[0]), 16'(ST_FIXED));
        chk("one_steps", 16'(steps_w[0]), 16'd4);
        chk("one_end", end_w[0], 16'h00);

        // step limit 3
        run_cmd(1, 16'h01, 1'b0, -1);
        wait_idle(1);
        chk("tmo_status", 16'(status_w[1]), 16'(ST_TIMEOUT));
        chk("tmo_steps", 16'(steps_w[1]), 16'd3);
        chk("tmo_end", end_w[1], 16'hAA);

        // detector fires while x=0x44
        run_cmd(0, 16'h01, 1'b0, 2);
        wait_idle(0);
        chk("cyc_status", 16'(status_w[0]), 16'(ST_CYCLE));
        chk("cyc_steps", 16'(steps_w[0]), 16'd2);
        chk("cyc_end", end_w[0], 16'h44);
        chk("cyc_count", cc_w[0], 16'd1);

        // N=4 full sweep with random detector, plus a start while busy
        seed_cnt[2] = 0; done_cnt[2] = 0;
        run_cmd(2, 16'h0, 1'b1, -2);
        repeat (10) @(negedge clk);
        #1;
        init_c = 4'h5; sweep_v[2] = 1'b0; start_v[2] = 1'b1;
        @(negedge clk); #1;
        start_v[2] = 1'b0;
        wait_idle(2);
        chk("sweep_seeds", 16'(seed_cnt[2]), 16'd16);
        chk("sweep_dones", 16'(done_cnt[2]), 16'd1);
        chk("sweep_cc", cc_w[2], m_cc[2]);

        // sweep ending at all-ones
        seed_cnt[0] = 0;
        run_cmd(0, 16'hFA, 1'b1, -2);
        wait_idle(0);
        chk("wrap_seeds", 16'(seed_cnt[0]), 16'd6);

        // random single runs
        for (int r = 0; r < 24; r++) begin
            int inst = int'($urandom_range(0, NI - 1));
            run_cmd(inst, 16'($urandom_range(0, (1 << cfg_n[inst]) - 1)), 1'b0, -2);
            wait_idle(inst);
        end
        run_cmd(1, 16'($urandom_range(240, 255)), 1'b1, -2);
        wait_idle(1);

        // async reset in the middle of a sweep
        run_cmd(2, 16'h0, 1'b1, -2);
        repeat (20) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) check_zero(i, "mid_reset");
        model_clear();
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0; cyc_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        seed_cnt[2] = 0; done_cnt[2] = 0;
        run_cmd(2, 16'h1, 1'b0, -1);
        wait_idle(2);
        chk("post_status", 16'(status_w[2]), 16'(ST_FIXED));
        chk("post_steps", 16'(steps_w[2]), 16'd2);
        chk("post_end", end_w[2], 16'h0);
        chk("post_seeds", 16'(seed_cnt[2]), 16'd1);
        chk("post_dones", 16'(done_cnt[2]), 16'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
